// File: rtl/ram_wb.sv
// ram_wb: write-back stage holding RAM words 0..7 and a handshaked output port register IO64.
module ram_wb #(
  parameter logic [7:0] IO_OUT_AD = 8'h40
) (
  input  logic        CLK_WB,
  input  logic        RESET,
  input  logic        WEN,
  input  logic [7:0]  RAM_AD_IN,
  input  logic [15:0] RAM_IN,
  input  logic        IO64_ACK,
  output logic [15:0] RAM0,
  output logic [15:0] RAM1,
  output logic [15:0] RAM2,
  output logic [15:0] RAM3,
  output logic [15:0] RAM4,
  output logic [15:0] RAM5,
  output logic [15:0] RAM6,
  output logic [15:0] RAM7,
  output logic [15:0] IO64_OUT,
  output logic        IO64_VALID,
  output logic        BUSY,
  output logic        AD_ERR,
  output logic        IO_OVR
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t      state_q, state_d;
  logic [15:0] ram_q [8];
  logic [15:0] io_q, io_d;
  logic        ad_err_q, ad_err_d, io_ovr_q, io_ovr_d, ram_hit, io_hit, io_load;
  // RAM words take precedence so a port address inside 0..7 cannot double-decode
  always_comb begin
    ram_hit  = WEN && (RAM_AD_IN < 8'd8);
    io_hit   = WEN && (RAM_AD_IN == IO_OUT_AD) && !ram_hit;
    io_load  = io_hit && (state_q == IDLE);
    io_ovr_d = io_hit && (state_q == PEND);
    ad_err_d = WEN && !ram_hit && !io_hit;
    io_d     = io_load ? RAM_IN : io_q;
    state_d  = io_load ? PEND : (IO64_ACK ? IDLE : state_q);
  end
  always_ff @(posedge CLK_WB or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < 8; i++) ram_q[i] <= '0;
      io_q     <= '0;
      state_q  <= IDLE;
      ad_err_q <= 1'b0;
      io_ovr_q <= 1'b0;
    end else begin
      if (ram_hit) ram_q[RAM_AD_IN[2:0]] <= RAM_IN;
      io_q     <= io_d;
      state_q  <= state_d;
      ad_err_q <= ad_err_d;
      io_ovr_q <= io_ovr_d;
    end
  end
  assign RAM0       = ram_q[0];
  assign RAM1       = ram_q[1];
  assign RAM2       = ram_q[2];
  assign RAM3       = ram_q[3];
  assign RAM4       = ram_q[4];
  assign RAM5       = ram_q[5];
  assign RAM6       = ram_q[6];
  assign RAM7       = ram_q[7];
  assign IO64_OUT   = io_q;
  assign IO64_VALID = (state_q == PEND);
  assign BUSY       = (state_q == PEND);
  assign AD_ERR     = ad_err_q;
  assign IO_OVR     = io_ovr_q;
endmodule

// File: doc/ram_wb.md
RAM_WB -- requirements
Module: ram_wb

Interface
REQ-001 SHALL provide parameter IO_OUT_AD, default 8'h40, meaning the RAM-map address of the output port register IO64.
REQ-002 SHALL provide CLK_WB  input  1  meaning write-back clock; all state updates on its rising edge.
REQ-003 SHALL provide RESET  input  1  meaning asynchronous, active-high reset.
REQ-004 SHALL provide WEN  input  1  meaning write request, valid for one cycle.
REQ-005 SHALL provide RAM_AD_IN  input  8  meaning write address.
REQ-006 SHALL provide RAM_IN  input  16  meaning write data.
REQ-007 SHALL provide IO64_ACK  input  1  meaning external output device has consumed IO64_OUT.
REQ-008 SHALL provide RAM0..RAM7  output  16 each  meaning registered contents of RAM words 0..7, fed to the RAM read decoder.
REQ-009 SHALL provide IO64_OUT  output  16  meaning registered output port data.
REQ-010 SHALL provide IO64_VALID  output  1  meaning IO64_OUT holds data not yet acknowledged.
REQ-011 SHALL provide BUSY  output  1  meaning output port pending; writes to IO_OUT_AD are not accepted.
REQ-012 SHALL provide AD_ERR  output  1  meaning one-cycle pulse: write to an unmapped address.
REQ-013 SHALL provide IO_OVR  output  1  meaning one-cycle pulse: write to IO_OUT_AD dropped because BUSY.

Function
REQ-014 SHALL implement a two-state output FSM: IDLE, PEND; BUSY = (state == PEND), IO64_VALID = (state == PEND), both registered.
REQ-015 SHALL, on an edge with WEN=1 and RAM_AD_IN in 0..7, load RAM[RAM_AD_IN] <= RAM_IN; new value visible on RAMn after that edge (1-cycle latency), other words unchanged.
REQ-016 SHALL accept RAM word writes (0..7) in both IDLE and PEND.
REQ-017 SHALL, on an edge with WEN=1, RAM_AD_IN=IO_OUT_AD and state IDLE, load IO64_OUT <= RAM_IN and go to PEND.
REQ-018 SHALL, on an edge with WEN=1, RAM_AD_IN=IO_OUT_AD and state PEND, leave IO64_OUT unchanged and assert IO_OVR for exactly the following cycle.
REQ-019 SHALL, on an edge with IO64_ACK=1 in PEND, go to IDLE; IO64_OUT retains its value.
REQ-020 SHALL ignore IO64_ACK in IDLE.
REQ-021 SHALL, for simultaneous IO64_ACK=1 and WEN=1 to IO_OUT_AD in PEND, evaluate against the pre-edge state: write dropped, IO_OVR pulses, state goes to IDLE.
REQ-022 SHALL, on an edge with WEN=1 and RAM_AD_IN not in {0..7, IO_OUT_AD}, change no storage and assert AD_ERR for exactly the following cycle.
REQ-023 SHALL ignore RAM_AD_IN and RAM_IN when WEN=0; AD_ERR and IO_OVR are 0 in every cycle not following a qualifying event.
REQ-024 SHALL compare the full 8-bit address; no aliasing (e.g. 8'h08 and 8'h48 are unmapped).

Reset
REQ-025 SHALL, while RESET=1, asynchronously force RAM0..RAM7=16'h0000, IO64_OUT=16'h0000, state IDLE, IO64_VALID=0, BUSY=0, AD_ERR=0, IO_OVR=0.
REQ-026 SHALL, on RESET asserted in PEND, drop IO64_VALID immediately without waiting for a clock edge; a write presented during the edge at which RESET is high is discarded.
REQ-027 SHALL resume normal operation on the first rising edge after RESET deasserts.

Verification
REQ-028 SHALL cover: reset, then WEN=1 AD=8'h03 DATA=16'h1234 -> next cycle RAM3=16'h1234, RAM0..2,4..7=0, AD_ERR=0.
REQ-029 SHALL cover: WEN=1 AD=8'h40 DATA=16'h00A5 in IDLE -> next cycle IO64_OUT=16'h00A5, IO64_VALID=1, BUSY=1; IO64_ACK=1 one cycle -> next cycle VALID=0, BUSY=0, IO64_OUT still 16'h00A5.
REQ-030 SHALL cover: in PEND, WEN=1 AD=8'h40 DATA=16'hBEEF with IO64_ACK=1 same edge -> IO64_OUT unchanged, IO_OVR=1 one cycle, state IDLE next cycle.
REQ-031 SHALL cover: WEN=1 AD=8'h48 DATA=16'hFFFF -> AD_ERR=1 one cycle, all RAMn and IO64_OUT unchanged.
REQ-032 SHALL cover: in PEND, WEN=1 AD=8'h07 DATA=16'h7FFF -> RAM7=16'h7FFF next cycle, VALID stays 1.
REQ-033 SHALL cover: RESET pulsed mid-cycle while PEND with RAM2=16'h0002 -> IO64_VALID, BUSY, RAM2 go to 0 before the next clock edge.
